// File: rtl/vrf_seq.sv
// vrf_seq: banked vector register file (one bank per lane) with a sequenced multi-operand read.
// Optional feature macro VRF_BYPASS_EN forwards same-cycle writes into the read path.
module vrf_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 32,
    parameter int LANES      = 4,
    parameter int NOPS       = 3
) (
    input  logic                                 clk_i,
    input  logic                                 resetn_i,
    input  logic                                 rd_req_i,
    input  logic [NOPS-1:0]                      rd_opsel_i,
    input  logic [NOPS*$clog2(REG_NUM)-1:0]      rd_addr_i,
    input  logic                                 mask_used_i,
    input  logic [$clog2(LANES)-1:0]             rd_elem_i,
    output logic                                 rd_busy_o,
    output logic                                 rd_done_o,
    output logic [NOPS*DATA_WIDTH-1:0]           op_rdata_o,
    output logic [DATA_WIDTH-1:0]                mask_rdata_o,
    input  logic                                 wr_en_i,
    input  logic [$clog2(REG_NUM)-1:0]           wr_addr_i,
    input  logic [$clog2(LANES)-1:0]             wr_elem_i,
    input  logic [DATA_WIDTH/8-1:0]              wr_be_i,
    input  logic [DATA_WIDTH-1:0]                wdata_i
);

    // state | meaning
    // IDLE  | waiting for rd_req_i; a zero-operand request only pulses rd_done_o
    // ISSUE | one pending operand address per cycle, lowest index first, v0 last
    // FLUSH | final capture of the last operand's bank data

    localparam int ADDR_B = $clog2(REG_NUM);
    localparam int ELEM_B = $clog2(LANES);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int IDX_B  = $clog2(NOPS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_FLUSH} state_t;

    state_t                   state_q, state_d;
    logic [NOPS:0]            pend_q, pend_d;
    logic [NOPS:0]            req_set;
    logic [NOPS*ADDR_B-1:0]   addr_q;
    logic [IDX_B-1:0]         cur_idx, cap_idx_q;
    logic [ADDR_B-1:0]        cur_addr;
    logic                     accept, issue, cap_vld_q, done_q;

    logic [DATA_WIDTH-1:0]    mem      [LANES][REG_NUM];
    logic [DATA_WIDTH-1:0]    rd_data  [LANES];
    logic [DATA_WIDTH-1:0]    rdata_q  [LANES];
    logic [DATA_WIDTH-1:0]    op_cap   [NOPS][LANES];
    logic [DATA_WIDTH-1:0]    mask_cap [LANES];

    assign req_set = {mask_used_i, rd_opsel_i};
    assign accept  = (state_q == ST_IDLE) && rd_req_i;
    assign issue   = (state_q == ST_ISSUE);

    // Bit NOPS of the pending set is the v0 mask operand, so it naturally goes last.
    always_comb begin
        cur_idx  = '0;
        cur_addr = '0;
        for (int k = NOPS; k >= 0; k--) begin
            if (pend_q[k]) cur_idx = IDX_B'(k);
        end
        for (int k = 0; k < NOPS; k++) begin
            if (cur_idx == IDX_B'(k)) cur_addr = addr_q[k*ADDR_B +: ADDR_B];
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && (req_set != '0)) begin
                    state_d = ST_ISSUE;
                    pend_d  = req_set;
                end
            end
            ST_ISSUE: begin
                pend_d[cur_idx] = 1'b0;
                if (pend_d == '0) state_d = ST_FLUSH;
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q   <= ST_IDLE;
            pend_q    <= '0;
            addr_q    <= '0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
            done_q    <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                mask_cap[l] <= '0;
                for (int k = 0; k < NOPS; k++) op_cap[k][l] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            if (accept) addr_q <= rd_addr_i;
            cap_vld_q <= issue;
            cap_idx_q <= cur_idx;
            done_q    <= (state_q == ST_FLUSH) || (accept && (req_set == '0));
            if (cap_vld_q) begin
                for (int l = 0; l < LANES; l++) begin
                    for (int k = 0; k < NOPS; k++) begin
                        if (cap_idx_q == IDX_B'(k)) op_cap[k][l] <= rdata_q[l];
                    end
                    if (cap_idx_q == IDX_B'(NOPS)) mask_cap[l] <= rdata_q[l];
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            rd_data[l] = mem[l][cur_addr];
`ifdef VRF_BYPASS_EN
            if (wr_en_i && (wr_addr_i == cur_addr) && (wr_elem_i == ELEM_B'(l))) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_be_i[b]) rd_data[l][b*8 +: 8] = wdata_i[b*8 +: 8];
                end
            end
`endif
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be_i[b]) mem[wr_elem_i][wr_addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
        if (issue) begin
            for (int l = 0; l < LANES; l++) rdata_q[l] <= rd_data[l];
        end
    end

    assign rd_busy_o    = (state_q != ST_IDLE);
    assign rd_done_o    = done_q;
    assign mask_rdata_o = mask_cap[rd_elem_i];

    for (genvar k = 0; k < NOPS; k++) begin : g_op_out
        assign op_rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = op_cap[k][rd_elem_i];
    end

endmodule

// File: tb/tb_vrf_seq.sv
// tb_vrf_seq: directed table-driven bench for vrf_seq plus hand-written corner sequences.
module tb_vrf_seq;

    logic        clk_i = 1'b0;
    logic        resetn_i = 1'b0;
    logic        rd_req_i = 1'b0;
    logic [2:0]  rd_opsel_i = '0;
    logic [14:0] rd_addr_i = '0;
    logic        mask_used_i = 1'b0;
    logic [1:0]  rd_elem_i = '0;
    logic        rd_busy_o, rd_done_o;
    logic [95:0] op_rdata_o;
    logic [31:0] mask_rdata_o;
    logic        wr_en_i = 1'b0;
    logic [4:0]  wr_addr_i = '0;
    logic [1:0]  wr_elem_i = '0;
    logic [3:0]  wr_be_i = '0;
    logic [31:0] wdata_i = '0;

    int n_vec = 0;
    int n_err = 0;

    vrf_seq dut (
        .clk_i(clk_i), .resetn_i(resetn_i), .rd_req_i(rd_req_i), .rd_opsel_i(rd_opsel_i),
        .rd_addr_i(rd_addr_i), .mask_used_i(mask_used_i), .rd_elem_i(rd_elem_i),
        .rd_busy_o(rd_busy_o), .rd_done_o(rd_done_o), .op_rdata_o(op_rdata_o),
        .mask_rdata_o(mask_rdata_o), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_elem_i(wr_elem_i), .wr_be_i(wr_be_i), .wdata_i(wdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  opsel;
        logic [4:0]  a0, a1, a2;
        logic        mask;
        bit          hold;
        int          busy;
        logic [1:0]  elem;
        logic [31:0] e0, e1, e2, em;
    } rvec_t;

    rvec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [1:0] el, input logic [3:0] be,
                            input logic [31:0] d);
        @(negedge clk_i);
        wr_en_i = 1'b1; wr_addr_i = a; wr_elem_i = el; wr_be_i = be; wdata_i = d;
        @(negedge clk_i);
        wr_en_i = 1'b0;
    endtask

    // Fixed 8-cycle observation window after the accept edge; optional write in the first address cycle.
    task automatic run_read(input logic [2:0] opsel, input logic [14:0] addrs, input logic mask,
                            input bit hold, input bit do_wr, input logic [4:0] wa,
                            input logic [31:0] wd, input int exp_busy, input string tag);
        int busy_cnt, done_cnt, done_idx;
        busy_cnt = 0; done_cnt = 0; done_idx = -1;
        @(negedge clk_i);
        rd_req_i = 1'b1; rd_opsel_i = opsel; rd_addr_i = addrs; mask_used_i = mask;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            busy_cnt += int'(rd_busy_o);
            if (rd_done_o) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            rd_req_i = hold && rd_busy_o;
            if (i == 0 && do_wr) begin
                wr_en_i = 1'b1; wr_addr_i = wa; wr_elem_i = 2'd0; wr_be_i = 4'hF; wdata_i = wd;
            end else begin
                wr_en_i = 1'b0;
            end
        end
        chk({tag, " busy_cycles"}, busy_cnt, exp_busy);
        chk({tag, " done_pulses"}, done_cnt, 1);
        chk({tag, " done_cycle"}, done_idx, exp_busy);
    endtask

    task automatic check_out(input logic [1:0] elem, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] em, input string tag);
        rd_elem_i = elem;
        #1;
        chk({tag, " op0"}, op_rdata_o[31:0], e0);
        chk({tag, " op1"}, op_rdata_o[63:32], e1);
        chk({tag, " op2"}, op_rdata_o[95:64], e2);
        chk({tag, " mask"}, mask_rdata_o, em);
    endtask

    initial begin
        tbl[0]  = '{3'b001, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 2, 2'd0, 32'h11, 32'h0, 32'h0, 32'h0};
        tbl[1]  = '{3'b001, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 2, 2'd1, 32'h22, 32'h0, 32'h0, 32'h0};
        tbl[2]  = '{3'b001, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 2, 2'd2, 32'h33, 32'h0, 32'h0, 32'h0};
        tbl[3]  = '{3'b001, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 2, 2'd3, 32'h44, 32'h0, 32'h0, 32'h0};
        tbl[4]  = '{3'b111, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 5, 2'd0,
                    32'h5000_0000, 32'h6000_0000, 32'h7000_0000, 32'hF0};
        tbl[5]  = '{3'b111, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 5, 2'd3,
                    32'h5000_0003, 32'h6000_0003, 32'h7000_0003, 32'hF3};
        tbl[6]  = '{3'b010, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 2, 2'd2,
                    32'h5000_0002, 32'h33, 32'h7000_0002, 32'hF2};
        tbl[7]  = '{3'b101, 5'd7, 5'd9, 5'd5, 1'b0, 1'b0, 3, 2'd1,
                    32'h7000_0001, 32'h22, 32'h5000_0001, 32'hF1};
        tbl[8]  = '{3'b000, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 2, 2'd0,
                    32'h7000_0000, 32'h11, 32'h5000_0000, 32'hF0};
        tbl[9]  = '{3'b000, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 0, 2'd2,
                    32'h7000_0002, 32'h33, 32'h5000_0002, 32'hF2};
        tbl[10] = '{3'b001, 5'd6, 5'd0, 5'd0, 1'b0, 1'b1, 2, 2'd3,
                    32'h6000_0003, 32'h44, 32'h5000_0003, 32'hF3};

        repeat (3) @(posedge clk_i);
        #1;
        chk("reset busy", {31'b0, rd_busy_o}, 32'h0);
        chk("reset done", {31'b0, rd_done_o}, 32'h0);
        check_out(2'd0, 32'h0, 32'h0, 32'h0, 32'h0, "reset");
        @(negedge clk_i);
        resetn_i = 1'b1;

        for (int l = 0; l < 4; l++) begin
            do_write(5'd3, 2'(l), 4'hF, 32'h11 * (l + 1));
            do_write(5'd5, 2'(l), 4'hF, 32'h5000_0000 + l);
            do_write(5'd6, 2'(l), 4'hF, 32'h6000_0000 + l);
            do_write(5'd7, 2'(l), 4'hF, 32'h7000_0000 + l);
            do_write(5'd0, 2'(l), 4'hF, 32'hF0 + l);
        end

        for (int i = 0; i < 11; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_read(tbl[i].opsel, {tbl[i].a2, tbl[i].a1, tbl[i].a0}, tbl[i].mask, tbl[i].hold,
                     1'b0, 5'd0, 32'h0, tbl[i].busy, tag);
            check_out(tbl[i].elem, tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].em, tag);
        end

        // Byte enables: partial write, no-op write, and lane isolation.
        do_write(5'd2, 2'd1, 4'hF, 32'hAABB_CCDD);
        do_write(5'd2, 2'd1, 4'h1, 32'h0000_0011);
        do_write(5'd2, 2'd1, 4'h0, 32'hFFFF_FFFF);
        do_write(5'd2, 2'd0, 4'hF, 32'h1234_5678);
        do_write(5'd2, 2'd0, 4'h4, 32'h00EE_0000);
        run_read(3'b001, {5'd0, 5'd0, 5'd2}, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 2, "be");
        rd_elem_i = 2'd1; #1;
        chk("be lane1", op_rdata_o[31:0], 32'hAABB_CC11);
        rd_elem_i = 2'd0; #1;
        chk("be lane0", op_rdata_o[31:0], 32'h12EE_5678);

        // Write colliding with the read address cycle.
        do_write(5'd4, 2'd0, 4'hF, 32'h1);
        run_read(3'b001, {5'd0, 5'd0, 5'd4}, 1'b0, 1'b0, 1'b1, 5'd4, 32'h5, 2, "coll");
        rd_elem_i = 2'd0; #1;
`ifdef VRF_BYPASS_EN
        chk("coll bypass", op_rdata_o[31:0], 32'h5);
`else
        chk("coll no_bypass", op_rdata_o[31:0], 32'h1);
`endif
        run_read(3'b001, {5'd0, 5'd0, 5'd4}, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 2, "coll_after");
        rd_elem_i = 2'd0; #1;
        chk("coll_after op0", op_rdata_o[31:0], 32'h5);

        // Reset asserted in the middle of ISSUE.
        @(negedge clk_i);
        rd_req_i = 1'b1; rd_opsel_i = 3'b111; rd_addr_i = {5'd7, 5'd6, 5'd5}; mask_used_i = 1'b1;
        @(negedge clk_i);
        rd_req_i = 1'b0;
        chk("rst_mid busy_before", {31'b0, rd_busy_o}, 32'h1);
        @(posedge clk_i);
        #2;
        resetn_i = 1'b0;
        #1;
        chk("rst_mid busy", {31'b0, rd_busy_o}, 32'h0);
        chk("rst_mid done", {31'b0, rd_done_o}, 32'h0);
        check_out(2'd0, 32'h0, 32'h0, 32'h0, 32'h0, "rst_mid");
        @(negedge clk_i);
        resetn_i = 1'b1;
        run_read(3'b001, {5'd0, 5'd0, 5'd3}, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 2, "post_rst");
        check_out(2'd0, 32'h11, 32'h0, 32'h0, 32'h0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
